// File: rtl/act_sched_pkg.sv
// Shared types, constants and helpers for the activation-unit share scheduler.
package act_sched_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int MAX_ID_W   = 4;
  localparam int PERF_W     = 32;

  typedef logic signed [DEF_DATA_W-1:0] act_data_t;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    act_data_t           data;
  } rsp_entry_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/act_rr_arbiter.sv
// Round-robin arbiter: grants the first valid requester at or after the
// pointer, then moves the pointer just past the winner.
module act_rr_arbiter
  import act_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] valid,
  input  logic             enable,
  output logic [N_REQ-1:0] grant
);

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gid;
  logic [ID_W-1:0] idx_l;
  logic            found;
  int              idx;

  // search from the pointer, wrapping modulo N_REQ
  always_comb begin
    grant = '0;
    gid   = '0;
    found = 1'b0;
    idx   = 0;
    idx_l = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      idx_l = ID_W'(idx);
      if (enable && !found && valid[idx_l]) begin
        found        = 1'b1;
        grant[idx_l] = 1'b1;
        gid          = idx_l;
      end
    end
  end

  // pointer advances past the winner; it holds when nothing is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (int'(gid) == N_REQ - 1) ? '0 : gid + 1'b1;
    end
  end

endmodule

// File: rtl/act_unit_share_sched.sv
// Shares one activation unit among N_REQ requesters. Results return in grant
// order through a credit-protected FIFO, so back-pressure never drops one.
// Optional performance counters: define ACT_SCHED_PERF_CNT_EN.
module act_unit_share_sched
  import act_sched_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int ACT_LAT   = 0,
  parameter  int RSP_DEPTH = 4,
  localparam int ID_W      = (clog2(N_REQ) < 1) ? 1 : clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_z,
  output logic [N_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]       act_z,
  input  logic [DATA_W-1:0]       act_a,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy
`ifdef ACT_SCHED_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0]       perf_issued,
  output logic [PERF_W-1:0]       perf_stall
`endif
);

  localparam int CNT_W = clog2(RSP_DEPTH + 1);
  localparam int PTR_W = clog2(RSP_DEPTH);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(RSP_DEPTH);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  logic [CNT_W-1:0]  inflight;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    credit_used;
  logic              credit_ok;
  logic              accept;
  logic              push;
  logic              pop;
  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   sel_id;
  logic [DATA_W-1:0] sel_z;
  logic [DATA_W-1:0] act_z_q;
  logic              tag_v  [ACT_LAT+1];
  logic [ID_W-1:0]   tag_id [ACT_LAT+1];
  logic [DATA_W-1:0] mem_data [RSP_DEPTH];
  logic [ID_W-1:0]   mem_id   [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;

  // credit comes from registered counts only, so rsp_ready never reaches req_ready
  assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
  assign credit_ok   = credit_used < DEPTH_W;

  act_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  (req_valid),
    .enable (credit_ok && !rst),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign accept    = |grant;

  // one-hot grant to requester index and its z value
  always_comb begin
    sel_id = '0;
    sel_z  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_id = ID_W'(i);
        sel_z  = req_z[i*DATA_W +: DATA_W];
      end
    end
  end

  // z register feeding the shared unit; holds when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      act_z_q <= '0;
    end else if (accept) begin
      act_z_q <= sel_z;
    end
  end

  assign act_z = act_z_q;

  // tag pipeline tracks the unit latency: ACT_LAT+1 stages of {valid, id}
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k <= ACT_LAT; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= accept;
      tag_id[0] <= sel_id;
      for (int k = 1; k <= ACT_LAT; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  assign push      = tag_v[ACT_LAT];
  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;

  // occupancy counters; a result moves from in-flight to buffered on push
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight   <= '0;
      fifo_count <= '0;
    end else begin
      inflight   <= inflight + CNT_W'(accept) - CNT_W'(push);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // response FIFO storage and pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int k = 0; k < RSP_DEPTH; k++) begin
        mem_data[k] <= '0;
        mem_id[k]   <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= act_a;
        mem_id[wr_ptr]   <= tag_id[ACT_LAT];
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  assign rsp_data = mem_data[rd_ptr];
  assign rsp_id   = mem_id[rd_ptr];
  assign busy     = (inflight != '0) || (fifo_count != '0);

  // credit guarantees a free slot for every push
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && (fifo_count == DEPTH_C)));
    end
  end

`ifdef ACT_SCHED_PERF_CNT_EN
  // issue and credit-stall counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_issued <= '0;
      perf_stall  <= '0;
    end else begin
      if (accept) perf_issued <= perf_issued + 1'b1;
      if ((|req_valid) && !credit_ok) perf_stall <= perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_act_unit_share_sched.sv
// Bench for act_unit_share_sched: one instance with a combinational unit and
// one with a two-stage unit; both modelled as act_a = z ^ 8'h5A.
`timescale 1ns/1ps
module tb_act_unit_share_sched;

  localparam int N        = 4;
  localparam int DW       = 8;
  localparam int DEPTH    = 4;
  localparam int MAX_WAIT = 60;

  typedef struct packed {
    logic [1:0]    id;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  // instance 0: ACT_LAT = 0
  logic [N-1:0]    req_valid = '0;
  logic [N*DW-1:0] req_z     = '0;
  logic [N-1:0]    req_ready;
  logic [DW-1:0]   act_z, act_a, rsp_data;
  logic            rsp_valid, busy;
  logic            rsp_ready = 1'b0;
  logic [1:0]      rsp_id;

  // instance 2: ACT_LAT = 2
  logic [N-1:0]    req_valid2 = '0;
  logic [N*DW-1:0] req_z2     = '0;
  logic [N-1:0]    req_ready2;
  logic [DW-1:0]   act_z2, act_a2, rsp_data2;
  logic            rsp_valid2, busy2;
  logic            rsp_ready2 = 1'b0;
  logic [1:0]      rsp_id2;
  logic [DW-1:0]   dly1, dly2;

`ifdef ACT_SCHED_PERF_CNT_EN
  logic [31:0] perf_issued0, perf_stall0, perf_issued2, perf_stall2;
`endif

  assign act_a = act_z ^ 8'h5A;

  always @(posedge clk) begin
    dly1 <= act_z2;
    dly2 <= dly1;
  end
  assign act_a2 = dly2 ^ 8'h5A;

  act_unit_share_sched #(.N_REQ(N), .DATA_W(DW), .ACT_LAT(0), .RSP_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_z(req_z), .req_ready(req_ready),
    .act_z(act_z), .act_a(act_a), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
`ifdef ACT_SCHED_PERF_CNT_EN
    , .perf_issued(perf_issued0), .perf_stall(perf_stall0)
`endif
  );

  act_unit_share_sched #(.N_REQ(N), .DATA_W(DW), .ACT_LAT(2), .RSP_DEPTH(DEPTH)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid2), .req_z(req_z2), .req_ready(req_ready2),
    .act_z(act_z2), .act_a(act_a2), .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .rsp_id(rsp_id2), .rsp_ready(rsp_ready2), .busy(busy2)
`ifdef ACT_SCHED_PERF_CNT_EN
    , .perf_issued(perf_issued2), .perf_stall(perf_stall2)
`endif
  );

  exp_t exp_q[$];
  exp_t exp_q2[$];

  // scoreboard for instance 0: push on grant, pop and compare on handshake
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if ($countones(req_ready) > 1) begin
        failures++;
        $display("FAIL grant_onehot0 req_ready=%b required at most one bit", req_ready);
      end
      for (int i = 0; i < N; i++)
        if (req_ready[i]) exp_q.push_back({2'(i), req_z[i*DW +: DW] ^ 8'h5A});
      if (rsp_valid && rsp_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb0_extra got id=%0d data=%h required no response", rsp_id, rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_id, rsp_data} !== e) begin
            failures++;
            $display("FAIL sb0_rsp got id=%0d data=%h required id=%0d data=%h",
                     rsp_id, rsp_data, e.id, e.data);
          end
        end
      end
    end
  end

  // scoreboard for instance 2
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      checks++;
      if ($countones(req_ready2) > 1) begin
        failures++;
        $display("FAIL grant_onehot2 req_ready=%b required at most one bit", req_ready2);
      end
      for (int i = 0; i < N; i++)
        if (req_ready2[i]) exp_q2.push_back({2'(i), req_z2[i*DW +: DW] ^ 8'h5A});
      if (rsp_valid2 && rsp_ready2) begin
        checks++;
        if (exp_q2.size() == 0) begin
          failures++;
          $display("FAIL sb2_extra got id=%0d data=%h required no response", rsp_id2, rsp_data2);
        end else begin
          e = exp_q2.pop_front();
          if ({rsp_id2, rsp_data2} !== e) begin
            failures++;
            $display("FAIL sb2_rsp got id=%0d data=%h required id=%0d data=%h",
                     rsp_id2, rsp_data2, e.id, e.data);
          end
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    exp_q.delete();
    exp_q2.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < MAX_WAIT; k++) begin
      @(negedge clk);
      if (!busy && !busy2 && exp_q.size() == 0 && exp_q2.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_valid2 = '1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || req_ready2 !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got %b/%b required 0000", req_ready, req_ready2);
    end
    checks++;
    if ({rsp_valid, busy, act_z, rsp_data, rsp_id} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b busy=%b z=%h d=%h id=%0d required all zero",
               rsp_valid, busy, act_z, rsp_data, rsp_id);
    end
    checks++;
    if ({rsp_valid2, busy2, act_z2} !== '0) begin
      failures++;
      $display("FAIL reset_outputs2 got v=%b busy=%b z=%h required all zero",
               rsp_valid2, busy2, act_z2);
    end
`ifdef ACT_SCHED_PERF_CNT_EN
    checks++;
    if (perf_issued0 !== 32'd0 || perf_stall0 !== 32'd0) begin
      failures++;
      $display("FAIL reset_perf got %0d/%0d required 0/0", perf_issued0, perf_stall0);
    end
`endif
    req_valid = '0;
    req_valid2 = '0;
    exp_q.delete();
    exp_q2.delete();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single();
    rsp_ready = 1'b1;
    req_z = '0;
    req_z[2*DW +: DW] = 8'h10;
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_grant got %b required 0100", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_early got rsp_valid=%b required 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h4A || rsp_id !== 2'd2) begin
      failures++;
      $display("FAIL single_rsp got v=%b d=%h id=%0d required v=1 d=4a id=2",
               rsp_valid, rsp_data, rsp_id);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fairness();
    bit ok;
    do_reset();
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      req_z = $urandom;
      @(negedge clk);
      checks++;
      if (req_ready !== 4'(1 << (k % 4))) begin
        failures++;
        $display("FAIL fair_grant step=%0d got %b required %b", k, req_ready, 4'(1 << (k % 4)));
      end
      @(posedge clk); #1;
    end
    req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL fair_drain got busy=%b pending=%0d required idle", busy, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int grants;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    grants = 0;
    for (int k = 0; k < 8; k++) begin
      req_z = $urandom;
      @(negedge clk);
      if (req_ready != '0) grants++;
      @(posedge clk); #1;
    end
    checks++;
    if (grants != DEPTH) begin
      failures++;
      $display("FAIL bp_grants got %0d required %0d", grants, DEPTH);
    end
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000 || busy !== 1'b1) begin
      failures++;
      $display("FAIL bp_stalled got ready=%b busy=%b required 0000/1", req_ready, busy);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL bp_first_pop got ready=%b required 0000", req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready === 4'b0000) begin
      failures++;
      $display("FAIL bp_resume got ready=%b required a grant", req_ready);
    end
    // full-credit steady state: push and pop every cycle
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      req_z = $urandom;
      @(negedge clk);
      checks++;
      if (req_ready === 4'b0000 || rsp_valid !== 1'b1) begin
        failures++;
        $display("FAIL steady step=%0d got ready=%b rsp_valid=%b required grant and 1",
                 k, req_ready, rsp_valid);
      end
    end
    @(posedge clk); #1;
    req_valid = '0;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL bp_drain got busy=%b pending=%0d required idle", busy, exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      req_z = $urandom;
      @(posedge clk); #1;
    end
    req_valid = '0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset got v=%b busy=%b required 0/0", rsp_valid, busy);
    end
    @(posedge clk); #1;
    req_z = $urandom;
    req_valid = 4'b1001;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_ptr got %b required 0001", req_ready);
    end
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++;
      $display("FAIL mid_next got %b required 1000", req_ready);
    end
    @(posedge clk); #1;
    req_valid = '0;
    rsp_ready = 1'b1;
    wait_idle(ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL mid_drain got busy=%b pending=%0d required idle", busy, exp_q.size());
    end
  endtask

  task automatic test_latency2();
    int  seq_done, burst_cnt, issued, stall_exp, lat;
    bit  waiting, seen, done;
    do_reset();
    seq_done = 0; burst_cnt = 0; issued = 0; stall_exp = 0; lat = 0;
    waiting = 1'b0; seen = 1'b0; done = 1'b0;
    rsp_ready2 = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      rsp_ready2 = ~rsp_ready2;
      req_z2 = $urandom;
      if (seq_done < 3) req_valid2 = waiting ? 4'b0000 : 4'(1 << seq_done);
      else if (burst_cnt < 7) req_valid2 = '1;
      else req_valid2 = '0;
      @(negedge clk);
      if (req_valid2 != '0 && req_ready2 == '0) stall_exp++;
      if (req_ready2 != '0) begin
        issued++;
        if (seq_done < 3) begin
          waiting = 1'b1; seen = 1'b0; lat = 0;
        end else begin
          burst_cnt++;
        end
      end else if (waiting) begin
        lat++;
        if (rsp_valid2 && !seen) begin
          seen = 1'b1;
          checks++;
          if (lat != 4) begin
            failures++;
            $display("FAIL lat2 req=%0d got %0d cycles required 4", seq_done, lat);
          end
        end
        if (seen && !busy2 && exp_q2.size() == 0) begin
          waiting = 1'b0;
          seq_done++;
        end
      end
      if (seq_done == 3 && burst_cnt == 7 && req_valid2 == '0 && !busy2 && exp_q2.size() == 0)
        done = 1'b1;
      @(posedge clk); #1;
    end
    req_valid2 = '0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL lat2_timeout got seq=%0d burst=%0d required 3/7 and idle", seq_done, burst_cnt);
    end
    checks++;
    if (issued != 10) begin
      failures++;
      $display("FAIL lat2_issued got %0d required 10", issued);
    end
`ifdef ACT_SCHED_PERF_CNT_EN
    checks++;
    if (perf_issued2 !== 32'd10) begin
      failures++;
      $display("FAIL perf_issued got %0d required 10", perf_issued2);
    end
    checks++;
    if (perf_stall2 !== 32'(stall_exp)) begin
      failures++;
      $display("FAIL perf_stall got %0d required %0d", perf_stall2, stall_exp);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_back_to_back();
    test_reset_mid();
    test_latency2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no finish required completion within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
